divisibility_checker: RTL and testbench
=======================================

DIVISIBILITY_CHECKER -- requirements
Module: divisibility_checker

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits, legal range >=1.
REQ-002 SHALL have parameter DIV_A, default 2, first divisor, legal range >=2.
REQ-003 SHALL have parameter DIV_B, default 3, second divisor, legal range >=2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  operand offered.
REQ-007 SHALL have port in_ready  output  1  block can accept an operand.
REQ-008 SHALL have port in_data  input  WIDTH  operand, unsigned.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_data  output  WIDTH  copy of the accepted operand.
REQ-012 SHALL have port by_a  output  1  operand divisible by DIV_A.
REQ-013 SHALL have port by_b  output  1  operand divisible by DIV_B.
REQ-014 SHALL have port by_ab  output  1  operand divisible by lcm(DIV_A,DIV_B), equal to by_a AND by_b.
REQ-015 SHALL have port rem_a  output  RA_W  operand mod DIV_A, where RA_W = max(1, clog2(DIV_A)).
REQ-016 SHALL have port rem_b  output  RB_W  operand mod DIV_B, where RB_W = max(1, clog2(DIV_B)).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL drive in_ready high only in IDLE.
REQ-019 SHALL accept an operand on a rising edge with in_valid=1 in IDLE, then latch in_data into a shift register and out_data, clear both remainders, load bit counter = WIDTH, and enter RUN.
REQ-020 SHALL consume one operand bit per cycle in RUN, MSB first, updating each remainder r as r <= (2*r + bit) mod D without division hardware (a conditional subtract is sufficient since 2*r+bit < 2*D).
REQ-021 SHALL decrement the bit counter each RUN cycle and enter DONE on the edge that processes bit 0, so out_valid rises exactly WIDTH rising edges after the accepting edge.
REQ-022 SHALL, in DONE, hold out_valid=1 with by_a=(rem_a==0), by_b=(rem_b==0), by_ab=by_a&by_b, with all result outputs stable until the handshake completes.
REQ-023 SHALL return to IDLE on a rising edge with out_valid=1 and out_ready=1.
REQ-024 SHALL NOT accept a new operand on the same edge as the DONE handshake, because in_ready is low in DONE; the earliest next accept is the following edge.
REQ-025 SHALL ignore in_data and in_valid while in RUN or DONE.
REQ-026 SHALL drive out_valid, by_a, by_b, and by_ab low outside DONE; rem_a, rem_b, and out_data show in-progress or last values outside DONE and are don't-care there.
REQ-027 SHALL report an operand of 0 as divisible by both divisors (by_a=by_b=by_ab=1, remainders 0).
REQ-028 SHALL, when WIDTH=1, assert out_valid one edge after acceptance.
REQ-029 SHALL sustain throughput of one operand per WIDTH+2 cycles with out_ready held high.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-RUN or in DONE, immediately force IDLE, in_ready=1 once released, out_valid=0, by_a=by_b=by_ab=0, rem_a=rem_b=0, out_data=0, counter and shift register 0, and discard the operation in progress.
REQ-031 SHALL make the first accept possible on the first rising edge after rst_n deasserts.

Verification
REQ-032 With WIDTH=4, DIV_A=2, DIV_B=3, the bench SHALL sweep operands 0..15 -> by_a/by_b/by_ab match 2/3/6 divisibility for every value (e.g. 6->1,1,1; 9->0,1,0 with rem_a=1, rem_b=0; 0->1,1,1).
REQ-033 With WIDTH=8, DIV_A=5, DIV_B=7, the bench SHALL check 35 -> 1,1,1 and 255 -> by_a=1, by_b=0, rem_b=3, with out_valid exactly 8 edges after acceptance.
REQ-034 The bench SHALL stall out_ready low for 5 cycles in DONE -> out_valid and outputs held constant; in_valid asserted meanwhile is not accepted (in_ready=0).
REQ-035 The bench SHALL pulse rst_n low mid-RUN -> outputs at reset values asynchronously, and the next operand (e.g. 12 with WIDTH=4) completes correctly (1,1,1).
REQ-036 The bench SHALL present back-to-back operands with in_valid and out_ready held high -> accepts spaced WIDTH+2 cycles apart, with no result lost or duplicated.
REQ-037 The bench SHALL set DIV_A=DIV_B=4 with WIDTH=4 and check 8 -> by_ab=1 and 6 -> by_ab=0, confirming lcm semantics.

Source files
------------

// File: rtl/divisibility_checker.sv
// Bit-serial divisibility checker: an accepted operand is consumed MSB first
// while both remainders are tracked, then results are held until handshake.
module divisibility_checker #(
    parameter int WIDTH = 4,
    parameter int DIV_A = 2,
    parameter int DIV_B = 3,
    localparam int RA_W = (DIV_A > 2) ? $clog2(DIV_A) : 1,
    localparam int RB_W = (DIV_B > 2) ? $clog2(DIV_B) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              by_a,
    output logic              by_b,
    output logic              by_ab,
    output logic [RA_W-1:0]   rem_a,
    output logic [RB_W-1:0]   rem_b
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [RA_W:0] DA = (RA_W + 1)'(DIV_A);
    localparam logic [RB_W:0] DB = (RB_W + 1)'(DIV_B);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [WIDTH-1:0]  shreg;
    logic [CNT_W-1:0]  cnt;
    logic [RA_W-1:0]   ra_nxt;
    logic [RB_W-1:0]   rb_nxt;

    // 2*r+bit is always below 2*D, so a single conditional subtract reduces it
    function automatic logic [RA_W-1:0] step_a(input logic [RA_W-1:0] r, input logic b);
        logic [RA_W:0] t;
        t = {r, b};
        return RA_W'((t >= DA) ? (t - DA) : t);
    endfunction

    function automatic logic [RB_W-1:0] step_b(input logic [RB_W-1:0] r, input logic b);
        logic [RB_W:0] t;
        t = {r, b};
        return RB_W'((t >= DB) ? (t - DB) : t);
    endfunction

    always_comb begin
        ra_nxt = step_a(rem_a, shreg[WIDTH-1]);
        rb_nxt = step_b(rem_b, shreg[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            by_a      <= 1'b0;
            by_b      <= 1'b0;
            by_ab     <= 1'b0;
            rem_a     <= '0;
            rem_b     <= '0;
            out_data  <= '0;
            cnt       <= '0;
            shreg     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        out_data <= in_data;
                        rem_a    <= '0;
                        rem_b    <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    rem_a <= ra_nxt;
                    rem_b <= rb_nxt;
                    shreg <= shreg << 1;
                    cnt   <= cnt - CNT_W'(1);
                    // flags are registered from the final remainders as bit 0 is consumed
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        by_a      <= (ra_nxt == '0);
                        by_b      <= (rb_nxt == '0);
                        by_ab     <= (ra_nxt == '0) && (rb_nxt == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        by_a      <= 1'b0;
                        by_b      <= 1'b0;
                        by_ab     <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divisibility_checker.sv
// Directed bench for divisibility_checker across four parameterisations;
// expected results come from a modulo model evaluated in the bench.
module tb_divisibility_checker;

  logic       clk;
  logic       rst_n;
  logic [7:0] d_in;
  logic [3:0] iv;
  logic [3:0] ordy;
  int         sel;
  int         checks;
  int         failures;

  task automatic fail_msg(input string tag);
    failures++;
    $error("FAIL %s", tag);
  endtask

  // instance A: WIDTH=4, 2/3
  logic a_ir, a_ov, a_ba, a_bb, a_bab;
  logic [3:0] a_od;
  logic [0:0] a_ra;
  logic [1:0] a_rb;
  // instance B: WIDTH=8, 5/7
  logic b_ir, b_ov, b_ba, b_bb, b_bab;
  logic [7:0] b_od;
  logic [2:0] b_ra;
  logic [2:0] b_rb;
  // instance C: WIDTH=4, 4/4
  logic c_ir, c_ov, c_ba, c_bb, c_bab;
  logic [3:0] c_od;
  logic [1:0] c_ra;
  logic [1:0] c_rb;
  // instance D: WIDTH=1, 2/3
  logic d_ir, d_ov, d_ba, d_bb, d_bab;
  logic [0:0] d_od;
  logic [0:0] d_ra;
  logic [1:0] d_rb;

  divisibility_checker #(.WIDTH(4), .DIV_A(2), .DIV_B(3)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(a_ir), .in_data(d_in[3:0]),
    .out_valid(a_ov), .out_ready(ordy[0]), .out_data(a_od), .by_a(a_ba), .by_b(a_bb),
    .by_ab(a_bab), .rem_a(a_ra), .rem_b(a_rb));

  divisibility_checker #(.WIDTH(8), .DIV_A(5), .DIV_B(7)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(b_ir), .in_data(d_in),
    .out_valid(b_ov), .out_ready(ordy[1]), .out_data(b_od), .by_a(b_ba), .by_b(b_bb),
    .by_ab(b_bab), .rem_a(b_ra), .rem_b(b_rb));

  divisibility_checker #(.WIDTH(4), .DIV_A(4), .DIV_B(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(c_ir), .in_data(d_in[3:0]),
    .out_valid(c_ov), .out_ready(ordy[2]), .out_data(c_od), .by_a(c_ba), .by_b(c_bb),
    .by_ab(c_bab), .rem_a(c_ra), .rem_b(c_rb));

  divisibility_checker #(.WIDTH(1), .DIV_A(2), .DIV_B(3)) u_d (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(d_ir), .in_data(d_in[0:0]),
    .out_valid(d_ov), .out_ready(ordy[3]), .out_data(d_od), .by_a(d_ba), .by_b(d_bb),
    .by_ab(d_bab), .rem_a(d_ra), .rem_b(d_rb));

  // selected-instance view, zero-extended to common widths
  logic       o_valid, o_rdy, o_ba, o_bb, o_bab;
  logic [7:0] o_data;
  logic [2:0] o_ra, o_rb;

  always_comb begin
    o_valid = 1'b0; o_rdy = 1'b0; o_ba = 1'b0; o_bb = 1'b0; o_bab = 1'b0;
    o_data = '0; o_ra = '0; o_rb = '0;
    case (sel)
      0: begin
        o_valid = a_ov; o_rdy = a_ir; o_ba = a_ba; o_bb = a_bb; o_bab = a_bab;
        o_data = {4'b0, a_od}; o_ra = {2'b0, a_ra}; o_rb = {1'b0, a_rb};
      end
      1: begin
        o_valid = b_ov; o_rdy = b_ir; o_ba = b_ba; o_bb = b_bb; o_bab = b_bab;
        o_data = b_od; o_ra = b_ra; o_rb = b_rb;
      end
      2: begin
        o_valid = c_ov; o_rdy = c_ir; o_ba = c_ba; o_bb = c_bb; o_bab = c_bab;
        o_data = {4'b0, c_od}; o_ra = {1'b0, c_ra}; o_rb = {1'b0, c_rb};
      end
      default: begin
        o_valid = d_ov; o_rdy = d_ir; o_ba = d_ba; o_bb = d_bb; o_bab = d_bab;
        o_data = {7'b0, d_od}; o_ra = {2'b0, d_ra}; o_rb = {1'b0, d_rb};
      end
    endcase
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic op(input int s, input logic [7:0] v, input int w, input int da, input int db);
    int lat;
    sel = s;
    d_in = v;
    iv[s] = 1'b1;
    #1;
    checks++; if (o_rdy !== 1'b1) fail_msg("accept_ready");
    @(posedge clk); #1;
    iv[s] = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != w) fail_msg("latency");
    checks++; if (o_data !== v) fail_msg("out_data");
    checks++; if (o_ba !== 1'((v % da) == 0)) fail_msg("by_a");
    checks++; if (o_bb !== 1'((v % db) == 0)) fail_msg("by_b");
    checks++; if (o_bab !== 1'(((v % da) == 0) && ((v % db) == 0))) fail_msg("by_ab");
    checks++; if (32'(o_ra) !== 32'(v % da)) fail_msg("rem_a");
    checks++; if (32'(o_rb) !== 32'(v % db)) fail_msg("rem_b");
    checks++; if (o_rdy !== 1'b0) fail_msg("ready_in_done");
    ordy[s] = 1'b1;
    @(posedge clk); #1;
    ordy[s] = 1'b0;
    checks++; if (o_valid !== 1'b0) fail_msg("valid_after_hs");
    checks++; if ({o_ba, o_bb, o_bab} !== 3'b000) fail_msg("flags_after_hs");
    checks++; if (o_rdy !== 1'b1) fail_msg("ready_after_hs");
  endtask

  logic [7:0] vals [4];
  int         acc [4];
  int         ni, no, lat;
  logic       s_rdy, s_ov, s_ba, s_bb, s_bab;
  logic [7:0] s_od;

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; d_in = '0; iv = '0; ordy = '0; sel = 0;
    #12;
    checks++; if (o_valid !== 1'b0) fail_msg("rst_valid");
    checks++; if (o_rdy !== 1'b1) fail_msg("rst_ready");
    checks++; if (o_data !== 8'd0) fail_msg("rst_data");
    checks++; if ({o_ba, o_bb, o_bab} !== 3'b000) fail_msg("rst_flags");
    rst_n = 1'b1;

    // full sweep of 4-bit operands against 2/3/6
    for (int unsigned v = 0; v < 16; v++) op(0, 8'(v), 4, 2, 3);

    op(1, 8'd35, 8, 5, 7);
    op(1, 8'd255, 8, 5, 7);
    op(1, 8'd0, 8, 5, 7);
    op(2, 8'd8, 4, 4, 4);
    op(2, 8'd6, 4, 4, 4);
    op(3, 8'd0, 1, 2, 3);
    op(3, 8'd1, 1, 2, 3);

    // stall in DONE with a competing operand offered
    sel = 0; d_in = 8'd9; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    lat = 0;
    while (!o_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) fail_msg("stall_latency");
    d_in = 8'd4; iv[0] = 1'b1;
    for (int unsigned k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++; if (o_valid !== 1'b1) fail_msg("stall_valid");
      checks++; if (o_rdy !== 1'b0) fail_msg("stall_ready");
      checks++; if (o_data !== 8'd9) fail_msg("stall_data");
      checks++; if ({o_ba, o_bb, o_bab} !== 3'b010) fail_msg("stall_flags");
      checks++; if ({o_ra, o_rb} !== {3'd1, 3'd0}) fail_msg("stall_rems");
    end
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0; iv[0] = 1'b0;
    checks++; if (o_rdy !== 1'b1) fail_msg("hs_no_accept_ready");
    checks++; if (o_valid !== 1'b0) fail_msg("hs_valid");

    // back-to-back with in_valid and out_ready held high
    vals[0] = 8'd12; vals[1] = 8'd9; vals[2] = 8'd0; vals[3] = 8'd7;
    ni = 0; no = 0;
    sel = 0; d_in = vals[0]; iv[0] = 1'b1; ordy[0] = 1'b1;
    #1;
    for (int unsigned c = 0; c < 40; c++) begin
      s_rdy = o_rdy; s_ov = o_valid; s_od = o_data;
      s_ba = o_ba; s_bb = o_bb; s_bab = o_bab;
      @(posedge clk); #1;
      if (s_ov) begin
        if (no < 4) begin
          checks++; if (s_od !== vals[no]) fail_msg("b2b_data");
          checks++; if (s_ba !== 1'((vals[no] % 2) == 0)) fail_msg("b2b_by_a");
          checks++; if (s_bb !== 1'((vals[no] % 3) == 0)) fail_msg("b2b_by_b");
          checks++; if (s_bab !== 1'((vals[no] % 6) == 0)) fail_msg("b2b_by_ab");
        end else begin
          checks++; if (no != 3) fail_msg("b2b_extra_result");
        end
        no++;
      end
      if (s_rdy && ni < 4) begin
        acc[ni] = int'(c);
        ni++;
        if (ni < 4) d_in = vals[ni];
        else iv[0] = 1'b0;
      end
    end
    ordy[0] = 1'b0; iv[0] = 1'b0;
    checks++; if (ni != 4) fail_msg("b2b_accepts");
    checks++; if (no != 4) fail_msg("b2b_results");
    for (int unsigned i = 0; i < 3; i++) begin
      checks++; if (acc[i+1] - acc[i] != 6) fail_msg("b2b_spacing");
    end

    // asynchronous reset in the middle of RUN
    sel = 0; d_in = 8'd13; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    checks++; if (o_rdy !== 1'b0) fail_msg("midrun_ready");
    rst_n = 1'b0;
    #1;
    checks++; if (o_valid !== 1'b0) fail_msg("arst_valid");
    checks++; if (o_rdy !== 1'b1) fail_msg("arst_ready");
    checks++; if (o_data !== 8'd0) fail_msg("arst_data");
    checks++; if ({o_ra, o_rb} !== 6'd0) fail_msg("arst_rems");
    checks++; if ({o_ba, o_bb, o_bab} !== 3'b000) fail_msg("arst_flags");
    #1;
    rst_n = 1'b1;
    op(0, 8'd12, 4, 2, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
